accum_alu_seq: RTL

//  Parametrised accumulator ALU: W-bit operand IN1 combined with accumulator feedback FBK = ACC[W-1:0].

---
 rtl/accum_alu_pkg.sv | 31 +++
 rtl/accum_alu_seq_divider.sv | 84 ++++++++
 rtl/accum_alu_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/accum_alu_pkg.sv
// Shared types for the sequential accumulator ALU: opcodes, FSM states,
// and the error-clearing opcode classification.
package accum_alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'b0000,
    OP_CLR    = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_MUL    = 4'b0100,
    OP_DIV    = 4'b0101,
    OP_MOD    = 4'b0110,
    OP_PRESET = 4'b1110,
    OP_RESET  = 4'b1111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Opcodes that zero the accumulator also wipe accumulated error bits:
  // CLR, RESET and every unassigned opcode (0111-1101, which act as CLR).
  function automatic logic op_clears_err(input logic [OP_W-1:0] op);
    return (op == OP_CLR) || (op == OP_RESET) ||
           ((op >= 4'b0111) && (op <= 4'b1101));
  endfunction

endpackage

// File: rtl/accum_alu_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock,
// W iterations after a start pulse. quotient/remainder carry the result of
// the iteration in progress, so they are final in the cycle where done=1
// and the consumer can register them on that same edge.
module seq_divider #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;

  logic [W:0]       shifted;
  logic [W:0]       trial;
  logic [W-1:0]     step_rem;
  logic [W-1:0]     step_quo;

  // One restoring step per cycle; load operands on start.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    done     = 1'b0;

    // Bring the next dividend bit into the partial remainder and try to subtract;
    // a set top bit of the trial difference means it went negative (restore).
    shifted  = {rem_q, quo_q[W-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    step_quo = {quo_q[W-2:0], ~trial[W]};

    quotient  = step_quo;
    remainder = step_rem;

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W - 1)) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/accum_alu_seq.sv
// accum_alu_seq: W-bit operand combined with the low half of a 2W-bit
// accumulator. Single-cycle ADD/SUB/CLR/PRESET/NOP; multi-cycle shift-add MUL
// and restoring DIV/MOD (via seq_divider) behind a valid/ready handshake.
// Build option ERR_STICKY_EN: ERR bits OR-accumulate until RST or a clearing op.
module accum_alu_seq #(
  parameter int unsigned W = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [W-1:0]   IN1,
  input  logic [3:0]     OP,
  output logic [2*W-1:0] OUT,
  output logic           OUT_VALID,
  output logic [1:0]     ERR
);

  import accum_alu_pkg::*;

  localparam int unsigned CNT_W = $clog2(W + 1);

`ifdef ERR_STICKY_EN
  localparam bit ERR_STICKY = 1'b1;
`else
  localparam bit ERR_STICKY = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [1:0]       err_q, err_d;
  logic             out_valid_q, out_valid_d;

  op_e              op_in;
  logic [W-1:0]     fbk;
  logic             accept;
  logic             retire;
  logic             finish;
  logic [1:0]       err_new;
  logic             err_clr;
  logic [W:0]       sum;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   prod_step;

  logic             div_start;
  logic             div_done;
  logic [W-1:0]     div_quo;
  logic [W-1:0]     div_rem;

  seq_divider #(.W(W)) u_div (
    .clk       (CLK),
    .rst       (RST),
    .start     (div_start),
    .dividend  (IN1),
    .divisor   (fbk),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next-state, accumulator/error update and multiplier step.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    retire      = 1'b0;
    err_new     = '0;
    err_clr     = 1'b0;
    div_start   = 1'b0;

    op_in  = op_e'(OP);
    fbk    = acc_q[W-1:0];
    accept = IN_VALID && (state_q == IDLE);
    sum    = {1'b0, IN1} + {1'b0, fbk};

    // Shift-add: low half of prod holds the not-yet-consumed multiplier bits,
    // high half the running partial product; each step adds and shifts right.
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + ({1'b0, mcand_q} & {(W+1){prod_q[0]}});
    prod_step = {mul_sum, prod_q[W-1:1]};

    finish = (op_q == OP_MUL) ? (cnt_q == CNT_W'(W - 1)) : div_done;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_in)
            OP_NOP: retire = 1'b1;
            OP_ADD: begin
              acc_d      = {{(W-1){1'b0}}, sum};
              err_new[0] = sum[W];
              retire     = 1'b1;
            end
            OP_SUB: begin
              acc_d      = {{W{1'b0}}, IN1} - {{W{1'b0}}, fbk};
              err_new[0] = (IN1 < fbk);
              retire     = 1'b1;
            end
            OP_PRESET: begin
              acc_d  = '1;
              retire = 1'b1;
            end
            OP_MUL: begin
              state_d = BUSY;
              cnt_d   = '0;
              op_d    = OP_MUL;
              mcand_d = IN1;
              prod_d  = {{W{1'b0}}, fbk};
            end
            OP_DIV, OP_MOD: begin
              if (fbk == '0) begin
                acc_d      = '0;
                err_new[1] = 1'b1;
                retire     = 1'b1;
              end else begin
                state_d   = BUSY;
                cnt_d     = '0;
                op_d      = op_in;
                div_start = 1'b1;
              end
            end
            default: begin
              acc_d   = '0;
              err_clr = op_clears_err(OP);
              retire  = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          prod_d = prod_step;
        end
        if (finish) begin
          state_d = IDLE;
          retire  = 1'b1;
          if (op_q == OP_MUL) begin
            acc_d = prod_step;
          end else if (op_q == OP_DIV) begin
            acc_d = {{W{1'b0}}, div_quo};
          end else begin
            acc_d = {{W{1'b0}}, div_rem};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      out_valid_d = 1'b1;
      err_d       = (ERR_STICKY && !err_clr) ? (err_q | err_new) : err_new;
    end
  end

  // Architectural and sequencing registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      mcand_q     <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT       = acc_q;
  assign OUT_VALID = out_valid_q;
  assign ERR       = err_q;

endmodule
